// File: rtl/mem_responder.sv
// Word-array responder for instruction-fetch and data-read ports with byte-strobed preload.
// Optional stall injection is compiled in with MEM_RESPONDER_STALL_INJECT_EN.
module mem_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter int LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        INST_RDEN,
   input  logic [31:0] INST_RADDR,
   output logic        INST_RVALID,
   output logic [31:0] INST_RDATA,
   input  logic        DATA_RDEN,
   input  logic [31:0] DATA_RADDR,
   output logic        DATA_RVALID,
   output logic [31:0] DATA_RDATA,
   output logic        MEM_WAIT,
   output logic        DATA_WAIT,
   input  logic        LOAD_WREN,
   input  logic [31:0] LOAD_WADDR,
   input  logic [31:0] LOAD_WDATA,
   input  logic [3:0]  LOAD_WSTRB,
   output logic        ERR
);
   localparam int AW = $clog2(DEPTH_WORDS);

   function automatic logic addr_ok(input logic [31:0] a);
      return (a >> (AW + 2)) == 32'd0;
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      return a[AW+1:2];
   endfunction

   logic inject;

`ifdef MEM_RESPONDER_STALL_INJECT_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11
   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge CLK) begin
      if (RST) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end

   assign inject = (lfsr_q[1:0] == 2'b00);
`else
   assign inject = 1'b0;
`endif

   logic        load_go, data_acc, inst_acc;
   logic [31:0] acc_addr;
   logic [AW-1:0] acc_idx;
   logic        acc_ok;
   logic [31:0] rd_word;
   logic        err_q, err_d;
   logic        unused_addr_lsbs;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [LATENCY-1:0] ivld_q, dvld_q;
   logic [31:0]        idat_q [LATENCY];
   logic [31:0]        ddat_q [LATENCY];

   assign MEM_WAIT  = ~RST & INST_RDEN & (LOAD_WREN | DATA_RDEN | inject);
   assign DATA_WAIT = ~RST & DATA_RDEN & (LOAD_WREN | inject);

   assign load_go  = ~RST & LOAD_WREN;
   assign data_acc = ~RST & DATA_RDEN & ~DATA_WAIT;
   assign inst_acc = ~RST & INST_RDEN & ~MEM_WAIT;

   // Single array port: the address follows the LOAD > DATA > INST priority
   always_comb begin
      acc_addr = INST_RADDR;
      if (LOAD_WREN)      acc_addr = LOAD_WADDR;
      else if (DATA_RDEN) acc_addr = DATA_RADDR;
   end

   assign acc_idx          = word_idx(acc_addr);
   assign acc_ok           = addr_ok(acc_addr);
   assign rd_word          = acc_ok ? mem_q[acc_idx] : 32'h0000_0000;
   assign err_d            = err_q | ((load_go | data_acc | inst_acc) & ~acc_ok);
   assign unused_addr_lsbs = ^acc_addr[1:0];

   always_ff @(posedge CLK) begin
      if (load_go && acc_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (LOAD_WSTRB[b]) mem_q[acc_idx][8*b +: 8] <= LOAD_WDATA[8*b +: 8];
         end
      end
   end

   // Data stages only move with their valid so the last stage holds between pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q  <= 1'b0;
         ivld_q <= '0;
         dvld_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            idat_q[i] <= 32'h0000_0000;
            ddat_q[i] <= 32'h0000_0000;
         end
      end else begin
         err_q     <= err_d;
         ivld_q[0] <= inst_acc;
         dvld_q[0] <= data_acc;
         if (inst_acc) idat_q[0] <= rd_word;
         if (data_acc) ddat_q[0] <= rd_word;
         for (int i = 1; i < LATENCY; i++) begin
            ivld_q[i] <= ivld_q[i-1];
            dvld_q[i] <= dvld_q[i-1];
            if (ivld_q[i-1]) idat_q[i] <= idat_q[i-1];
            if (dvld_q[i-1]) ddat_q[i] <= ddat_q[i-1];
         end
      end
   end

   assign INST_RVALID = ivld_q[LATENCY-1];
   assign INST_RDATA  = idat_q[LATENCY-1];
   assign DATA_RVALID = dvld_q[LATENCY-1];
   assign DATA_RDATA  = ddat_q[LATENCY-1];
   assign ERR         = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a cycle-schedule reference model predicts
// responses, WAIT outputs and ERR from the arbitration and latency rules.
module tb_mem_responder;
   localparam int DW  = 4096;
   localparam int AW  = 12;
   localparam int LAT = 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        INST_RDEN, DATA_RDEN, LOAD_WREN;
   logic [31:0] INST_RADDR, DATA_RADDR, LOAD_WADDR, LOAD_WDATA;
   logic [3:0]  LOAD_WSTRB;
   logic        INST_RVALID, DATA_RVALID, MEM_WAIT, DATA_WAIT, ERR;
   logic [31:0] INST_RDATA, DATA_RDATA;

   always #5 CLK = ~CLK;

   mem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
      .CLK(CLK), .RST(RST),
      .INST_RDEN(INST_RDEN), .INST_RADDR(INST_RADDR),
      .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
      .DATA_RDEN(DATA_RDEN), .DATA_RADDR(DATA_RADDR),
      .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
      .MEM_WAIT(MEM_WAIT), .DATA_WAIT(DATA_WAIT),
      .LOAD_WREN(LOAD_WREN), .LOAD_WADDR(LOAD_WADDR),
      .LOAD_WDATA(LOAD_WDATA), .LOAD_WSTRB(LOAD_WSTRB),
      .ERR(ERR)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference model: memory contents plus expected responses keyed by cycle count
   logic [31:0] ref_mem [DW];
   bit          ev_i [64];
   bit          ev_d [64];
   logic [31:0] ed_i [64];
   logic [31:0] ed_d [64];
   logic [31:0] last_i, last_d;
   bit          ref_err;
   int          ncyc;

   function automatic bit in_range(input logic [31:0] a);
      return (a >> (AW + 2)) == 32'd0;
   endfunction

   task automatic clear_sched();
      for (int i = 0; i < 64; i++) begin
         ev_i[i] = 1'b0;
         ev_d[i] = 1'b0;
      end
   endtask

   // Called at a negedge: check outputs, drive inputs, predict, then advance one cycle
   task automatic cycle(input bit rst, input bit ir, input logic [31:0] ia,
                        input bit dr, input logic [31:0] da,
                        input bit lw, input logic [31:0] la, input logic [31:0] ld,
                        input logic [3:0] ls);
      int s;
      int t;
      bit exp_mw;
      bit exp_dw;
      s = ncyc % 64;
      if (ev_i[s]) last_i = ed_i[s];
      if (ev_d[s]) last_d = ed_d[s];
      chk("inst_rvalid", 32'(INST_RVALID), 32'(ev_i[s]));
      chk("inst_rdata", INST_RDATA, last_i);
      chk("data_rvalid", 32'(DATA_RVALID), 32'(ev_d[s]));
      chk("data_rdata", DATA_RDATA, last_d);
      chk("err", 32'(ERR), 32'(ref_err));
      ev_i[s] = 1'b0;
      ev_d[s] = 1'b0;

      RST = rst; INST_RDEN = ir; INST_RADDR = ia; DATA_RDEN = dr; DATA_RADDR = da;
      LOAD_WREN = lw; LOAD_WADDR = la; LOAD_WDATA = ld; LOAD_WSTRB = ls;
      #1;
      exp_mw = !rst && ir && (lw || dr);
      exp_dw = !rst && dr && lw;
      chk("mem_wait", 32'(MEM_WAIT), 32'(exp_mw));
      chk("data_wait", 32'(DATA_WAIT), 32'(exp_dw));

      if (rst) begin
         clear_sched();
         last_i  = 32'h0;
         last_d  = 32'h0;
         ref_err = 1'b0;
      end else begin
         t = (ncyc + LAT) % 64;
         if (lw) begin
            if (in_range(la)) begin
               for (int b = 0; b < 4; b++)
                  if (ls[b]) ref_mem[la[AW+1:2]][8*b +: 8] = ld[8*b +: 8];
            end else ref_err = 1'b1;
         end else if (dr) begin
            ev_d[t] = 1'b1;
            ed_d[t] = in_range(da) ? ref_mem[da[AW+1:2]] : 32'h0;
            if (!in_range(da)) ref_err = 1'b1;
         end else if (ir) begin
            ev_i[t] = 1'b1;
            ed_i[t] = in_range(ia) ? ref_mem[ia[AW+1:2]] : 32'h0;
            if (!in_range(ia)) ref_err = 1'b1;
         end
      end
      @(posedge CLK);
      ncyc++;
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
   endtask

   task automatic ld(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
      cycle(0, 0, 0, 0, 0, 1, a, d, st);
   endtask

   task automatic ird(input logic [31:0] a);
      cycle(0, 1, a, 0, 0, 0, 0, 0, 4'h0);
   endtask

   logic [31:0] ra, rb, rc;

   initial begin
      RST = 1'b1; INST_RDEN = 0; DATA_RDEN = 0; LOAD_WREN = 0;
      INST_RADDR = 0; DATA_RADDR = 0; LOAD_WADDR = 0; LOAD_WDATA = 0; LOAD_WSTRB = 0;
      clear_sched();
      last_i = 0; last_d = 0; ref_err = 0; ncyc = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);

      // Single fetch of word 0
      ld(32'h0, 32'h0000_0013, 4'hF);
      idle(1);
      ird(32'h0);
      idle(3);

      // Eight back-to-back fetches
      for (int i = 0; i < 8; i++) ld(32'(i * 4), 32'(i + 1), 4'hF);
      for (int i = 0; i < 8; i++) ird(32'(i * 4));
      idle(3);

      // Remaining words used by the random phase
      for (int i = 8; i < 64; i++) ld(32'(i * 4), $urandom, 4'hF);
      ld(32'h100, 32'hD00D_F00D, 4'hF);

      // Same-cycle fetch and data read: data wins, fetch retried
      cycle(0, 1, 32'h4, 1, 32'h100, 0, 0, 0, 4'h0);
      ird(32'h4);
      idle(3);

      // Partial-strobe load blocking a fetch, then read back
      ld(32'h10, 32'h1122_3344, 4'hF);
      cycle(0, 1, 32'h10, 0, 0, 1, 32'h10, 32'hAABB_CCDD, 4'b0011);
      ird(32'h10);
      ld(32'h10, 32'hFFFF_FFFF, 4'b0000);
      ird(32'h10);
      idle(3);

      // Out-of-range data read sets sticky ERR
      cycle(0, 0, 0, 1, 32'h0000_4000, 0, 0, 0, 4'h0);
      idle(4);

      // Reset while a read is in flight
      ird(32'h8);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
      idle(4);

      for (int n = 0; n < 1500; n++) begin
         ra = 32'($urandom_range(0, 255));
         rb = 32'($urandom_range(0, 255));
         rc = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0) ra = ra | (32'h1 << $urandom_range(AW + 2, 31));
         if ($urandom_range(0, 15) == 0) rb = rb | (32'h1 << $urandom_range(AW + 2, 31));
         if ($urandom_range(0, 31) == 0) rc = rc | (32'h1 << $urandom_range(AW + 2, 31));
         cycle(($urandom_range(0, 199) == 0),
               1'($urandom_range(0, 1)), ra,
               ($urandom_range(0, 2) == 0), rb,
               ($urandom_range(0, 5) == 0), rc, $urandom, 4'($urandom_range(0, 15)));
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
